branch_resolution_unit: RTL
===========================

// Module: branch_resolution_unit
// PURPOSE
//  Resolution-side partner of the fetch-stage BHT/BTB predictor. Records each predicted
//  branch at fetch (up to 2 per cycle) in an in-order queue, checks it against the
//  actual outcome from the Memory stage (up to 2 per cycle), and drives two outputs:
//  - registered predictor updates (branch/taken/pcM/targetM);
//  - a misprediction redirect with flush.
//  Sits between the Memory stage, the predictor update port and the PC mux.
// PARAMETERS
//  PC_W   9   PC / target width.
//  DEPTH  8   in-flight branch entries; power of 2, >=4.
//  PTR_W  3   log2(DEPTH).
// PORTS
//  clk          in   1      clock.
//  reset        in   1      async active-low reset.
//  push1        in   1      fetch slot 1 holds a branch; this is the older slot.
//  push2        in   1      fetch slot 2 holds a branch.
//  push_pc1/2   in   PC_W   branch PC per slot.
//  push_pred1/2 in   1      predicted taken per slot.
//  push_tgt1/2  in   PC_W   predicted target per slot.
//  full         out  1      count > DEPTH-2; fetch must stall branch issue.
//  res1         in   1      oldest outstanding branch resolves this cycle.
//  res2         in   1      second-oldest resolves; valid only with res1.
//  res_taken1/2 in   1      actual direction.
//  res_tgt1/2   in   PC_W   actual taken target.
//  upd_branch1/2 out 1      predictor update strobe.
//  upd_taken1/2  out 1      actual direction for the update.
//  upd_pc1/2     out PC_W   PC of the resolved branch.
//  upd_tgt1/2    out PC_W   actual target for the update.
//  mispredict   out  1      1-cycle pulse: redirect fetch and flush younger work.
//  redirect_pc  out  PC_W   correct next PC; valid while mispredict=1.
//  count        out  PTR_W+1  occupied entries.
// BEHAVIOUR
//  - Reset (async, reset=0): wr_ptr=rd_ptr=0, count=0; all upd_*, mispredict and
//    redirect_pc are 0; full=0.
//  - Push:
//    - push1 writes at wr_ptr, then push2 writes at wr_ptr+1. If only push2 is set,
//      it writes at wr_ptr.
//    - Pointers wrap mod DEPTH.
//    - Any push while full=1 is dropped with no state change for that slot.
//  - Resolve (head entry = oldest):
//    - res1 pops head and compares it against the res1 outcome.
//    - Entry mismatch (per slot) = (pred != taken) | (taken & pred & tgt != res_tgt).
//    - res2 pops head+1 only if res1 matched and count >= 2.
//    - res2 without res1 is ignored.
//    - res1 with count==0 is ignored; no update, no mispredict.
//  - Outputs, registered with 1-cycle latency from res*:
//    - upd_branchN=1 for each entry actually popped; upd_pcN is the stored PC.
//    - upd_takenN and upd_tgtN come from the res inputs. If not taken, upd_tgtN=pc+1.
//    - Slot-2 outputs are 0 when res1 mispredicted; that branch is on the wrong path.
//  - mispredict=1 the cycle after the first mismatching slot is resolved.
//    - redirect_pc = taken ? res_tgt : pc+1, with PC_W wrap.
//    - Only the oldest mismatch is reported.
//  - Flush, on the same edge that raises mispredict:
//    - rd_ptr=wr_ptr=0, count=0.
//    - Pushes arriving in that cycle are discarded; they are wrong-path.
//  - Otherwise count_next = count + accepted pushes - pops. No over/underflow is
//    possible: full is asserted with 2 slots' margin, and pops are limited by count.
//  - Simultaneous push and pop on the same entry index is legal. Reads use pre-edge
//    storage; there is no bypass, so resolving in the same cycle as a push never pops
//    the new entry.
//  - reset asserted mid-operation clears everything immediately; the storage array
//    need not be cleared.
// STRUCTURE
//  - Shared package (bpu_pkg): PC_W, DEPTH, the entry typedef/struct
//    {pc, pred, tgt}, and the mismatch function.
//  - One sub-module: bru_queue, a dual-push/dual-pop circular buffer (storage, pointers,
//    count, full). Compare, flush and output registers stay in the top.
// TESTING
//  1. Reset, then push1 pc=0x010 pred=1 tgt=0x040. Next cycle res1 taken tgt=0x040
//     -> upd_branch1=1, upd_pc1=0x010, upd_tgt1=0x040, mispredict=0, count back to 0.
//  2. Push pc=0x020 pred=0. res1 taken tgt=0x080 -> mispredict=1, redirect_pc=0x080,
//     count=0, upd_taken1=1.
//  3. Dual push 0x030/0x031 pred=0/0. Dual resolve: slot1 taken tgt=0x050, slot2 not
//     taken -> mispredict, redirect=0x050, upd_branch2=0, queue flushed.
//  4. Push 7 entries -> full=1 at count=7. Further push is dropped. Pop all 7 via
//     dual resolves -> correct PCs in order across wrap, full=0.
//  5. Pushes and correct resolves for 20 cycles -> no mispredict and count stays
//     consistent. Then res1 with count=0 -> no upd, no mispredict.
//  6. Assert reset mid-stream with count=5 -> count=0, outputs 0; pushes after reset
//     resolve correctly.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch resolution path: queue entry layout
// and the predicted-vs-actual comparison used at resolve time.
package bpu_pkg;
  localparam int PC_W  = 9;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
    logic [PC_W-1:0] tgt;
  } entry_t;

  function automatic logic is_mismatch(input entry_t e, input logic taken,
                                       input logic [PC_W-1:0] res_tgt);
    return (e.pred != taken) | (taken & e.pred & (e.tgt != res_tgt));
  endfunction

  // Architecturally correct next PC once the real outcome is known.
  function automatic logic [PC_W-1:0] next_pc(input entry_t e, input logic taken,
                                              input logic [PC_W-1:0] res_tgt);
    return taken ? res_tgt : PC_W'(e.pc + 1'b1);
  endfunction
endpackage

// File: rtl/bru_queue.sv
// Dual-push / dual-pop circular buffer holding in-flight predicted branches,
// oldest at rd_ptr. Pushes and pops arrive already qualified by the top.
module bru_queue
  import bpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push1,
  input  logic             push2,
  input  entry_t           entry1,
  input  entry_t           entry2,
  input  logic [1:0]       pop_cnt,
  input  logic             flush,
  output entry_t           head0,
  output entry_t           head1,
  output logic [PTR_W:0]   count,
  output logic             full
);
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1, slot2_idx;
  logic [PTR_W:0]   n_push;

  assign wr_ptr_p1 = wr_ptr + 1'b1;
  assign rd_ptr_p1 = rd_ptr + 1'b1;
  // A lone push2 takes the slot push1 would have used.
  assign slot2_idx = push1 ? wr_ptr_p1 : wr_ptr;
  assign n_push    = (PTR_W+1)'(push1) + (PTR_W+1)'(push2);

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr_p1];
  assign full  = count > (PTR_W+1)'(DEPTH-2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      count  <= count + n_push - (PTR_W+1)'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push1) mem[wr_ptr]    <= entry1;
    if (push2) mem[slot2_idx] <= entry2;
  end
endmodule

// File: rtl/branch_resolution_unit.sv
// Checks resolved branches from Memory against the queued fetch-time predictions,
// emitting registered predictor updates and a one-cycle redirect/flush on mismatch.
module branch_resolution_unit
  import bpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push1,
  input  logic             push2,
  input  logic [PC_W-1:0]  push_pc1,
  input  logic [PC_W-1:0]  push_pc2,
  input  logic             push_pred1,
  input  logic             push_pred2,
  input  logic [PC_W-1:0]  push_tgt1,
  input  logic [PC_W-1:0]  push_tgt2,
  output logic             full,
  input  logic             res1,
  input  logic             res2,
  input  logic             res_taken1,
  input  logic             res_taken2,
  input  logic [PC_W-1:0]  res_tgt1,
  input  logic [PC_W-1:0]  res_tgt2,
  output logic             upd_branch1,
  output logic             upd_branch2,
  output logic             upd_taken1,
  output logic             upd_taken2,
  output logic [PC_W-1:0]  upd_pc1,
  output logic [PC_W-1:0]  upd_pc2,
  output logic [PC_W-1:0]  upd_tgt1,
  output logic [PC_W-1:0]  upd_tgt2,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [PTR_W:0]   count
);
  entry_t          entry1, entry2, head0, head1;
  logic            accept, pop1, pop2, mis1, mis2, flush;
  logic [1:0]      pop_cnt;
  logic [PC_W-1:0] npc1, npc2;

  assign entry1 = '{pc: push_pc1, pred: push_pred1, tgt: push_tgt1};
  assign entry2 = '{pc: push_pc2, pred: push_pred2, tgt: push_tgt2};

  // Fetch push contract: a slot is taken whenever pushN=1 and full=0 in the same
  // cycle; there is no retry, so pushes while full or during a flush are lost.
  assign accept = !full && !flush;

  assign pop1    = res1 && (count != '0);
  assign mis1    = pop1 && is_mismatch(head0, res_taken1, res_tgt1);
  assign pop2    = pop1 && !mis1 && res2 && (count >= (PTR_W+1)'(2));
  assign mis2    = pop2 && is_mismatch(head1, res_taken2, res_tgt2);
  assign flush   = mis1 || mis2;
  assign pop_cnt = {1'b0, pop1} + {1'b0, pop2};
  assign npc1    = next_pc(head0, res_taken1, res_tgt1);
  assign npc2    = next_pc(head1, res_taken2, res_tgt2);

  bru_queue u_queue (
    .clk     (clk),
    .reset   (reset),
    .push1   (push1 && accept),
    .push2   (push2 && accept),
    .entry1  (entry1),
    .entry2  (entry2),
    .pop_cnt (pop_cnt),
    .flush   (flush),
    .head0   (head0),
    .head1   (head1),
    .count   (count),
    .full    (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_branch1 <= 1'b0;
      upd_branch2 <= 1'b0;
      upd_taken1  <= 1'b0;
      upd_taken2  <= 1'b0;
      upd_pc1     <= '0;
      upd_pc2     <= '0;
      upd_tgt1    <= '0;
      upd_tgt2    <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_branch1 <= pop1;
      upd_taken1  <= pop1 && res_taken1;
      upd_pc1     <= pop1 ? head0.pc : '0;
      upd_tgt1    <= pop1 ? npc1 : '0;
      upd_branch2 <= pop2;
      upd_taken2  <= pop2 && res_taken2;
      upd_pc2     <= pop2 ? head1.pc : '0;
      upd_tgt2    <= pop2 ? npc2 : '0;
      mispredict  <= flush;
      redirect_pc <= mis1 ? npc1 : (mis2 ? npc2 : '0);
    end
  end
endmodule
